// File: rtl/dcache_ctrl.sv
// dcache_ctrl: miss/store sequencer for a two-way set-associative data cache.
// Detects hits from the array's per-way compare, stalls the pipeline on load
// misses and stores, runs the main-memory request/ready handshake, refills the
// victim way and keeps one LRU bit per set. Stores are write-through and
// no-write-allocate.
//
// Optional feature: define DCACHE_PERF_EN to add hit_count/miss_count outputs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | decode cpu_req; load hits are served here with no stall
// RD_MISS | memory read outstanding for a load miss
// REFILL  | write fill buffer into the victim way, return data to the CPU
// ST_WAIT | write-through store outstanding; update array on hit at ready
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_addr_mode,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  arr_hit0,
  input  logic                  arr_hit1,
  input  logic                  arr_valid0,
  input  logic                  arr_valid1,
  input  logic [DATA_WIDTH-1:0] arr_rdata,
  output logic [3:0]            arr_set,
  output logic                  arr_way,
  output logic                  arr_fill_en,
  output logic                  arr_write_en,
  output logic [DATA_WIDTH-1:0] arr_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_addr_mode,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    REFILL  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SETS-1:0]       lru_q, lru_d;
  logic                  victim_q, victim_d;
  logic [DATA_WIDTH-1:0] fill_buf_q, fill_buf_d;
  logic                  st_hit_q, st_hit_d;
  logic                  st_way_q, st_way_d;

  logic [3:0] set_idx;
  logic       hit;
  logic       hit_way;
  logic       victim_sel;

  assign set_idx = cpu_addr[5:2];
  assign hit     = arr_hit0 | arr_hit1;
  // Way 0 wins if the array ever reports both ways hitting.
  assign hit_way = ~arr_hit0;
  // Prefer an empty way; only consult LRU when the set is full.
  assign victim_sel = !arr_valid0 ? 1'b0 :
                      !arr_valid1 ? 1'b1 : lru_q[set_idx];

  assign arr_set       = set_idx;
  assign mem_addr      = cpu_we ? cpu_addr : {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_addr_mode = cpu_addr_mode;
  assign mem_wdata     = cpu_wdata;

  // State and bookkeeping registers; reset discards any in-flight fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      fill_buf_q <= '0;
      st_hit_q   <= 1'b0;
      st_way_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lru_q      <= lru_d;
      victim_q   <= victim_d;
      fill_buf_q <= fill_buf_d;
      st_hit_q   <= st_hit_d;
      st_way_q   <= st_way_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    lru_d        = lru_q;
    victim_d     = victim_q;
    fill_buf_d   = fill_buf_q;
    st_hit_d     = st_hit_q;
    st_way_d     = st_way_q;
    cpu_rdata    = '0;
    cpu_stall    = 1'b0;
    arr_way      = 1'b0;
    arr_fill_en  = 1'b0;
    arr_write_en = 1'b0;
    arr_wdata    = cpu_wdata;
    mem_req      = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            st_hit_d  = hit;
            st_way_d  = hit_way;
            state_d   = ST_WAIT;
          end else if (hit) begin
            cpu_rdata        = arr_rdata;
            lru_d[set_idx]   = ~hit_way;
          end else begin
            cpu_stall = 1'b1;
            victim_d  = victim_sel;
            state_d   = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_req   = 1'b1;
        cpu_stall = 1'b1;
        if (mem_ready) begin
          fill_buf_d = mem_rdata;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        arr_fill_en    = 1'b1;
        arr_way        = victim_q;
        arr_wdata      = fill_buf_q;
        cpu_rdata      = fill_buf_q;
        lru_d[set_idx] = ~victim_q;
        state_d        = IDLE;
      end
      ST_WAIT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        cpu_stall = ~mem_ready;
        arr_way   = st_way_q;
        if (mem_ready) begin
          if (st_hit_q) begin
            arr_write_en   = 1'b1;
            lru_d[set_idx] = ~st_way_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Loads resolve in IDLE; stores resolve on the ST_WAIT ready cycle.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && cpu_req && !cpu_we) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
    if (state_q == ST_WAIT && mem_ready) begin
      if (st_hit_q) hit_count_d  = hit_count_q + 32'd1;
      else          miss_count_d = miss_count_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl. The bench plays the cache array (tags/valid/data per
// set and way) and main memory; expected values come from a memory model and
// a per-set LRU model built from the replacement rules.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_addr_mode;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        arr_hit0, arr_hit1, arr_valid0, arr_valid1;
  logic [31:0] arr_rdata;
  logic [3:0]  arr_set;
  logic        arr_way, arr_fill_en, arr_write_en;
  logic [31:0] arr_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_addr_mode;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
  int          ref_hits, ref_misses;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr_mode(cpu_addr_mode),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .arr_hit0(arr_hit0), .arr_hit1(arr_hit1),
    .arr_valid0(arr_valid0), .arr_valid1(arr_valid1), .arr_rdata(arr_rdata),
    .arr_set(arr_set), .arr_way(arr_way), .arr_fill_en(arr_fill_en),
    .arr_write_en(arr_write_en), .arr_wdata(arr_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_addr_mode(mem_addr_mode), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sized store merge shared by the array and memory models.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] mode, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (mode[1:0])
      2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Array model driven by the DUT's fill/write strobes.
  bit        a_valid [16][2];
  bit [25:0] a_tag   [16][2];
  bit [31:0] a_data  [16][2];
  logic      ovr, ovr_h0, ovr_h1;
  logic [31:0] ovr_rdata;
  logic [3:0]  cs;
  logic        t_h0, t_h1;

  assign cs         = cpu_addr[5:2];
  assign t_h0       = a_valid[cs][0] && (a_tag[cs][0] == cpu_addr[31:6]);
  assign t_h1       = a_valid[cs][1] && (a_tag[cs][1] == cpu_addr[31:6]);
  assign arr_hit0   = ovr ? ovr_h0 : t_h0;
  assign arr_hit1   = ovr ? ovr_h1 : t_h1;
  assign arr_valid0 = ovr ? 1'b1 : a_valid[cs][0];
  assign arr_valid1 = ovr ? 1'b1 : a_valid[cs][1];
  assign arr_rdata  = ovr ? ovr_rdata : (t_h0 ? a_data[cs][0] : (t_h1 ? a_data[cs][1] : 32'h0));

  always @(posedge clk) begin
    if (arr_fill_en) begin
      a_valid[arr_set][arr_way] <= 1'b1;
      a_tag[arr_set][arr_way]   <= cpu_addr[31:6];
      a_data[arr_set][arr_way]  <= arr_wdata;
    end else if (arr_write_en) begin
      a_data[arr_set][arr_way] <= merge(a_data[arr_set][arr_way], arr_wdata,
                                        cpu_addr_mode, cpu_addr[1:0]);
    end
  end

  // Memory and replacement models.
  logic [31:0] mem_m [logic [31:0]];
  bit          ref_lru [16];

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic do_load(input logic [31:0] addr, input int lat);
    logic [31:0] wa, exp;
    logic [3:0]  s;
    logic        h0, h1;
    int          v;
    wa = {addr[31:2], 2'b00};
    exp = mem_get(wa);
    s = addr[5:2];
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_addr_mode = 3'b010;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    h0 = t_h0; h1 = t_h1;
    chk("ld_dec_memreq", 32'(mem_req), 32'd0);
    if (h0 || h1) begin
      chk("ld_hit_stall", 32'(cpu_stall), 32'd0);
      chk("ld_hit_rdata", cpu_rdata, exp);
      ref_lru[s] = h0;
`ifdef DCACHE_PERF_EN
      ref_hits++;
`endif
    end else begin
      v = !a_valid[s][0] ? 0 : (!a_valid[s][1] ? 1 : int'(ref_lru[s]));
      chk("ld_miss_dec_stall", 32'(cpu_stall), 32'd1);
`ifdef DCACHE_PERF_EN
      ref_misses++;
`endif
      for (int c = 1; c <= lat; c++) begin
        @(posedge clk); #1;
        mem_ready = (c == lat);
        mem_rdata = (c == lat) ? exp : 32'hBAD0_0000 + 32'(c);
        @(negedge clk);
        chk("rdmiss_req", 32'(mem_req), 32'd1);
        chk("rdmiss_we", 32'(mem_we), 32'd0);
        chk("rdmiss_stall", 32'(cpu_stall), 32'd1);
        chk("rdmiss_addr", mem_addr, wa);
        chk("rdmiss_fill", 32'(arr_fill_en), 32'd0);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      chk("refill_en", 32'(arr_fill_en), 32'd1);
      chk("refill_way", 32'(arr_way), 32'(v));
      chk("refill_wdata", arr_wdata, exp);
      chk("refill_rdata", cpu_rdata, exp);
      chk("refill_stall", 32'(cpu_stall), 32'd0);
      chk("refill_req", 32'(mem_req), 32'd0);
      ref_lru[s] = (v == 0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("ld_post_req", 32'(mem_req), 32'd0);
    chk("ld_post_fill", 32'(arr_fill_en), 32'd0);
    chk("ld_post_stall", 32'(cpu_stall), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] mode, input int lat);
    logic [31:0] wa;
    logic [3:0]  s;
    logic        h0, h1, hit, hw;
    wa = {addr[31:2], 2'b00};
    s = addr[5:2];
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = wd; cpu_addr_mode = mode;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    h0 = t_h0; h1 = t_h1; hit = h0 | h1; hw = !h0;
    chk("st_dec_stall", 32'(cpu_stall), 32'd1);
    chk("st_dec_req", 32'(mem_req), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      mem_ready = (c == lat);
      @(negedge clk);
      chk("st_req", 32'(mem_req), 32'd1);
      chk("st_we", 32'(mem_we), 32'd1);
      chk("st_addr", mem_addr, addr);
      chk("st_mode", 32'(mem_addr_mode), 32'(mode));
      chk("st_wdata", mem_wdata, wd);
      chk("st_stall", 32'(cpu_stall), 32'(c != lat));
      chk("st_write_en", 32'(arr_write_en), 32'((c == lat) && hit));
      chk("st_fill_en", 32'(arr_fill_en), 32'd0);
      if (c == lat && hit) begin
        chk("st_way", 32'(arr_way), 32'(hw));
        chk("st_arr_wdata", arr_wdata, wd);
      end
    end
    mem_m[wa] = merge(mem_get(wa), wd, mode, addr[1:0]);
    if (hit) ref_lru[s] = !hw;
`ifdef DCACHE_PERF_EN
    if (hit) ref_hits++;
    else     ref_misses++;
`endif
    @(posedge clk); #1;
    cpu_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("st_post_req", 32'(mem_req), 32'd0);
    chk("st_post_wen", 32'(arr_write_en), 32'd0);
    chk("st_post_stall", 32'(cpu_stall), 32'd0);
  endtask

  typedef struct {
    logic        req, we, h0, h1;
    logic [31:0] addr, rdata;
    logic        exp_stall, chk_rd;
    logic [31:0] exp_rdata, exp_maddr;
    logic [3:0]  exp_set;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] a;
    int tg, st, lat, m, off;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h1111_1111, 1'b0, 1'b1, 32'h0, 32'h0000_0044, 4'd1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0047, 32'hCAFE_0001, 1'b0, 1'b1, 32'hCAFE_0001, 32'h0000_0044, 4'd1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0014, 4'd5};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'h0000_003C, 4'd15};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF3, 32'h0000_0099, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0, 4'd12};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0089, 32'h0000_0077, 1'b1, 1'b0, 32'h0, 32'h0000_0089, 4'd2};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1236, 32'h0000_0055, 1'b1, 1'b0, 32'h0, 32'h0000_1236, 4'd13};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0082, 32'h3333_3333, 1'b0, 1'b1, 32'h0, 32'h0000_0080, 4'd0};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_addr_mode = 3'b010;
    mem_ready = 1'b0; mem_rdata = '0;
    ovr = 1'b0; ovr_h0 = 1'b0; ovr_h1 = 1'b0; ovr_rdata = '0;
`ifdef DCACHE_PERF_EN
    ref_hits = 0; ref_misses = 0;
`endif

    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_fill_en", 32'(arr_fill_en), 32'd0);
    chk("rst_write_en", 32'(arr_write_en), 32'd0);
`ifdef DCACHE_PERF_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // IDLE decode table; cpu_req is dropped before each edge so state stays IDLE.
    ovr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
      ovr_h0 = vecs[i].h0; ovr_h1 = vecs[i].h1; ovr_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].exp_stall));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'd0);
      chk($sformatf("vec%0d_maddr", i), mem_addr, vecs[i].exp_maddr);
      chk($sformatf("vec%0d_set", i), 32'(arr_set), 32'(vecs[i].exp_set));
      chk($sformatf("vec%0d_fill", i), 32'(arr_fill_en), 32'd0);
      #1 cpu_req = 1'b0;
    end
    ovr = 1'b0;

    // Cold miss of set 0 with a three-cycle memory latency.
    mem_m[32'h40] = 32'hDEAD_BEEF;
    do_load(32'h0000_0040, 3);
    // Set 5: fill way 1, hit way 0, hit way 1, then miss must evict way 0.
    mem_m[32'h54] = 32'h1234_5678;
    do_load(32'h0000_0014, 1);
    do_load(32'h0000_0054, 2);
    do_load(32'h0000_0014, 1);
    do_load(32'h0000_0054, 1);
    do_load(32'h0000_0094, 2);
    // Set 2: fill both ways, hit way 0, byte store hit, then victim is way 1.
    do_load(32'h0000_0088, 1);
    do_load(32'h0000_00C8, 1);
    do_load(32'h0000_0088, 1);
    do_store(32'h0000_0089, 32'h0000_00AB, 3'b000, 2);
    do_load(32'h0000_0088, 1);
    do_load(32'h0000_0108, 2);
    do_load(32'h0000_0148, 1);
    // Store miss leaves array and LRU alone.
    do_store(32'h0000_2008, 32'h0BAD_F00D, 3'b010, 1);
    do_load(32'h0000_0188, 1);

    for (int n = 0; n < 200; n++) begin
      tg = $urandom_range(0, 3);
      st = $urandom_range(0, 15);
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 2) == 0) begin
        m = $urandom_range(0, 2);
        off = (m == 0) ? $urandom_range(0, 3) : ((m == 1) ? 2 * $urandom_range(0, 1) : 0);
        a = (32'(tg) << 6) | (32'(st) << 2) | 32'(off);
        do_store(a, $urandom, 3'(m), lat);
      end else begin
        a = (32'(tg) << 6) | (32'(st) << 2) | 32'($urandom_range(0, 3));
        do_load(a, lat);
      end
    end

    // Reset during the second RD_MISS cycle.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0264; mem_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_dec_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_c1_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'hFEED_FACE;
    chk("rstmid_c2_req", 32'(mem_req), 32'd1);
    #1 rst = 1'b1;
    #1 chk("rstmid_req_drop", 32'(mem_req), 32'd0);
    chk("rstmid_no_fill", 32'(arr_fill_en), 32'd0);
    @(posedge clk); #1;
    chk("rstmid_no_fill2", 32'(arr_fill_en), 32'd0);
    cpu_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_lru[i] = 1'b0;
`ifdef DCACHE_PERF_EN
    ref_hits = 0; ref_misses = 0;
    chk("rstmid_hit_count", hit_count, 32'd0);
    chk("rstmid_miss_count", miss_count, 32'd0);
`endif
    chk("rstmid_idle_req", 32'(mem_req), 32'd0);
    do_load(32'h0000_0264, 1);
    for (int s = 0; s < 16; s++) do_load((32'd6 << 6) | (32'(s) << 2), 1);

    for (int n = 0; n < 50; n++) begin
      tg = $urandom_range(0, 3);
      st = $urandom_range(0, 15);
      a = (32'(tg) << 6) | (32'(st) << 2);
      if ($urandom_range(0, 3) == 0) do_store(a, $urandom, 3'b010, $urandom_range(1, 3));
      else                           do_load(a, $urandom_range(1, 3));
    end

`ifdef DCACHE_PERF_EN
    @(negedge clk);
    chk("end_hit_count", hit_count, 32'(ref_hits));
    chk("end_miss_count", miss_count, 32'(ref_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
